mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port 32-bit instruction/data memory between two requesters: port 0 = instruction fetch, port 1 = data load/store.
- Arbitrates round-robin. Registers the winning address, write data and write enable onto the memory port. Returns registered read data with a one-cycle ack pulse.
- Sits between the CPU core and the memory block. The memory has a combinational read and a synchronous write on posedge clk when we=1.

Parameters:
- AW, 16, address width (memory addr port width)
- DW, 32, data width (memory data/wdata width)

Ports:
- clk  input  1  system clock; all registers on posedge
- rst_n  input  1  asynchronous, active-low reset
- req0  input  1  port 0 request; level, held until ack0
- addr0  input  AW  port 0 address
- wdata0  input  DW  port 0 write data
- we0  input  1  port 0 write (1) / read (0)
- ack0  output  1  port 0 completion pulse, one cycle
- rdata0  output  DW  port 0 read data, valid while ack0=1
- req1, addr1, wdata1, we1, ack1, rdata1: same as port 0, for port 1
- mem_addr  output  AW  to memory addr
- mem_wdata  output  DW  to memory wdata
- mem_we  output  1  to memory we
- mem_data  input  DW  from memory data (combinational read)
- busy  output  1  1 while an access is in flight (state BUSY)

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: ack0=ack1=0, rdata0=rdata1=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, state=IDLE, last=1 (port 0 wins the first tie).
- States:
  - IDLE: sample req0/req1.
    - Neither high: stay in IDLE.
    - Exactly one high: grant that port.
    - Both high: grant port (1-last).
    - On grant, at the posedge: latch sel, mem_addr<=addrX, mem_wdata<=wdataX, mem_we<=weX, last<=sel, busy<=1, state->BUSY.
  - BUSY (exactly 1 cycle): memory sees the stable addr/we/wdata for the whole cycle. At the posedge:
    - memory performs the write if mem_we=1;
    - if the access is a read, rdata_sel<=mem_data;
    - ack_sel<=1, mem_we<=0, busy<=0, state->IDLE.
- Latency: req sampled high in cycle N -> ack in cycle N+2 when uncontended.
- ack is a single-cycle pulse. The non-granted rdata register holds its previous value.
- Write ack: rdata_sel is left unchanged.
- Requester contract: addr/wdata/we must be stable from req rise until ack. req still high in the ack cycle counts as a new request, with the values presented in that cycle. This gives back-to-back throughput of 1 access per 2 cycles.
- The arbiter never samples req while in BUSY. A request arriving during BUSY waits in IDLE for the next arbitration.
- Starvation bound: with both ports requesting continuously, grants alternate 0,1,0,1..., so each port waits at most one access.
- mem_we is 1 only during the BUSY cycle of a write and never 1 in IDLE.
- Reset mid-BUSY: all outputs return to their reset values asynchronously. mem_we falls immediately, so the write is not performed. No ack is issued and the requester must re-request.
- Addresses pass through unmodified. Address range checking is not done here.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 1 (data) always wins when both request; the `last` register is not implemented. Port 0 may starve while port 1 requests continuously.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset, then req0=1, addr0=0x0003, we0=0 with mem[3]=0xDEADBEEF -> mem_addr=0x0003 and busy=1 in cycle 2, ack0=1 and rdata0=0xDEADBEEF in cycle 3, ack1 stays 0.
- Port 1 write: req1=1, addr1=0x0005, wdata1=0x12345678, we1=1 -> mem_we=1 for exactly one cycle, ack1 pulses, then a port 0 read of 0x0005 returns 0x12345678. rdata1 is unchanged by the write.
- req0 and req1 both held high from reset for 8 cycles -> grant order 0,1,0,1, with an ack every 2 cycles alternating ack0/ack1. With MEM_ARB_FIXED_PRIO_EN defined -> ack1 only, ack0 never.
- req0 rises while port 1 is in BUSY -> port 0 is granted in the following IDLE cycle and ack0 arrives 2 cycles after ack1.
- rst_n driven low during the BUSY cycle of a write to 0x0007 (old value 0x0) -> mem_we=0 immediately, no ack, and a later read of 0x0007 returns 0x0.
- req0 held high across ack0 with addr0 changed from 0x0001 to 0x0002 in the ack cycle -> second ack0 exactly 2 cycles later with rdata0=mem[2].

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto a single-port memory; one access per two cycles.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority to port 1.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req0,
  input  logic [AW-1:0] i_addr0,
  input  logic [DW-1:0] i_wdata0,
  input  logic          i_we0,
  output logic          o_ack0,
  output logic [DW-1:0] o_rdata0,
  input  logic          i_req1,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata1,
  input  logic          i_we1,
  output logic          o_ack1,
  output logic [DW-1:0] o_rdata1,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_data,
  output logic          o_busy
);

  // state | meaning
  // IDLE  | arbitrate req0/req1, latch winner onto memory port
  // BUSY  | memory sees stable addr/we/wdata; capture read data, pulse ack
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sel, w_sel_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic          r_ack0, w_ack0_nxt;
  logic          r_ack1, w_ack1_nxt;
  logic [DW-1:0] r_rdata0, w_rdata0_nxt;
  logic [DW-1:0] r_rdata1, w_rdata1_nxt;
  logic          w_gnt_sel;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_gnt_sel = i_req1;
`else
  logic r_last, w_last_nxt;

  // On a tie the port that did not win last time goes next.
  assign w_gnt_sel = (i_req0 && i_req1) ? ~r_last : i_req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= 1'b1;
    else        r_last <= w_last_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_ack0      <= w_ack0_nxt;
      r_ack1      <= w_ack1_nxt;
      r_rdata0    <= w_rdata0_nxt;
      r_rdata1    <= w_rdata1_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_nxt    = r_mem_we;
    w_ack0_nxt      = 1'b0;
    w_ack1_nxt      = 1'b0;
    w_rdata0_nxt    = r_rdata0;
    w_rdata1_nxt    = r_rdata1;
`ifndef MEM_ARB_FIXED_PRIO_EN
    w_last_nxt      = r_last;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          w_sel_nxt       = w_gnt_sel;
          w_mem_addr_nxt  = w_gnt_sel ? i_addr1  : i_addr0;
          w_mem_wdata_nxt = w_gnt_sel ? i_wdata1 : i_wdata0;
          w_mem_we_nxt    = w_gnt_sel ? i_we1    : i_we0;
          w_state_nxt     = ST_BUSY;
`ifndef MEM_ARB_FIXED_PRIO_EN
          w_last_nxt      = w_gnt_sel;
`endif
        end
      end
      ST_BUSY: begin
        // Writes leave the requester's rdata register untouched.
        if (!r_mem_we) begin
          if (r_sel) w_rdata1_nxt = i_mem_data;
          else       w_rdata0_nxt = i_mem_data;
        end
        if (r_sel) w_ack1_nxt = 1'b1;
        else       w_ack0_nxt = 1'b1;
        w_mem_we_nxt = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_rdata0    = r_rdata0;
  assign o_rdata1    = r_rdata1;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_busy      = (r_state == ST_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_data;
  logic          busy;

  logic [DW-1:0] mem [0:255];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req0     (req0),
    .i_addr0    (addr0),
    .i_wdata0   (wdata0),
    .i_we0      (we0),
    .o_ack0     (ack0),
    .o_rdata0   (rdata0),
    .i_req1     (req1),
    .i_addr1    (addr1),
    .i_wdata1   (wdata1),
    .i_we1      (we1),
    .o_ack1     (ack1),
    .o_rdata1   (rdata1),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_mem_we   (mem_we),
    .i_mem_data (mem_data),
    .o_busy     (busy)
  );

  // Memory contents survive arbiter resets; only mem_rst_n preloads them.
  always @(posedge clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[1] <= 32'hA5A5_0001;
      mem[2] <= 32'hCAFE_0002;
      mem[3] <= 32'hDEAD_BEEF;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  assign mem_data = mem[mem_addr[7:0]];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_acks [1:8];

  initial begin
    rst_n = 1'b0; mem_rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    step(); step();
    chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_we_busy", {30'd0, mem_we, busy}, 32'd0);
    rst_n = 1'b1; mem_rst_n = 1'b1;
    step();

    // port 0 read of 0x0003
    req0 = 1; addr0 = 16'h0003; we0 = 0;
    step();
    chk("t1_mem_addr", {16'd0, mem_addr}, 32'h3);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_noack", {30'd0, ack1, ack0}, 32'd0);
    step();
    chk("t1_ack", {30'd0, ack1, ack0}, 32'b01);
    chk("t1_rdata0", rdata0, 32'hDEAD_BEEF);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    req0 = 0;
    step();
    chk("t1_pulse", {30'd0, ack1, ack0}, 32'd0);
    chk("t1_hold", rdata0, 32'hDEAD_BEEF);

    // port 1 write of 0x12345678 to 0x0005
    req1 = 1; addr1 = 16'h0005; wdata1 = 32'h1234_5678; we1 = 1;
    step();
    chk("t2_we", {31'd0, mem_we}, 32'd1);
    chk("t2_addr", {16'd0, mem_addr}, 32'h5);
    chk("t2_wdata", mem_wdata, 32'h1234_5678);
    step();
    chk("t2_ack", {30'd0, ack1, ack0}, 32'b10);
    chk("t2_we_off", {31'd0, mem_we}, 32'd0);
    chk("t2_rdata1", rdata1, 32'd0);
    req1 = 0; we1 = 0;
    req0 = 1; addr0 = 16'h0005; we0 = 0;
    step();
    chk("t2_rd_we", {31'd0, mem_we}, 32'd0);
    step();
    chk("t2_rd_ack", {30'd0, ack1, ack0}, 32'b01);
    chk("t2_rd_data", rdata0, 32'h1234_5678);
    req0 = 0;
    step();

    // req0 rises while port 1 is in BUSY
    req1 = 1; addr1 = 16'h0002; we1 = 0;
    step();
    req0 = 1; addr0 = 16'h0003;
    chk("t4_busy1", {31'd0, busy}, 32'd1);
    step();
    chk("t4_ack1", {30'd0, ack1, ack0}, 32'b10);
    chk("t4_rdata1", rdata1, 32'hCAFE_0002);
    req1 = 0;
    step();
    chk("t4_gnt0", {16'd0, mem_addr}, 32'h3);
    chk("t4_noack", {30'd0, ack1, ack0}, 32'd0);
    step();
    chk("t4_ack0", {30'd0, ack1, ack0}, 32'b01);
    chk("t4_rdata0", rdata0, 32'hDEAD_BEEF);
    req0 = 0;
    step();

    // both requesting continuously from a fresh reset
    rst_n = 0; step(); rst_n = 1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_acks = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
`else
    exp_acks = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
`endif
    req0 = 1; addr0 = 16'h0001; we0 = 0;
    req1 = 1; addr1 = 16'h0002; we1 = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t3_acks_c%0d", k), {30'd0, ack1, ack0}, {30'd0, exp_acks[k]});
    end
    req0 = 0; req1 = 0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    chk("t3_rdata0", rdata0, 32'hA5A5_0001);
`endif
    chk("t3_rdata1", rdata1, 32'hCAFE_0002);
    step();

    // reset during the BUSY cycle of a write to 0x0007
    req1 = 1; addr1 = 16'h0007; wdata1 = 32'hBAD0_BAD0; we1 = 1;
    step();
    chk("t5_we_pre", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("t5_we_drop", {31'd0, mem_we}, 32'd0);
    chk("t5_busy_drop", {31'd0, busy}, 32'd0);
    chk("t5_addr_drop", {16'd0, mem_addr}, 32'd0);
    req1 = 0; we1 = 0;
    step();
    chk("t5_noack", {30'd0, ack1, ack0}, 32'd0);
    rst_n = 1;
    step();
    chk("t5_noack2", {30'd0, ack1, ack0}, 32'd0);
    req0 = 1; addr0 = 16'h0007; we0 = 0;
    step(); step();
    chk("t5_rd_ack", {30'd0, ack1, ack0}, 32'b01);
    chk("t5_rd_data", rdata0, 32'h0);
    req0 = 0;
    step();

    // req0 held across ack0 with a new address
    req0 = 1; addr0 = 16'h0001; we0 = 0;
    step(); step();
    chk("t6_ack_a", {30'd0, ack1, ack0}, 32'b01);
    chk("t6_rdata_a", rdata0, 32'hA5A5_0001);
    addr0 = 16'h0002;
    step();
    chk("t6_gap", {30'd0, ack1, ack0}, 32'd0);
    chk("t6_addr_b", {16'd0, mem_addr}, 32'h2);
    step();
    chk("t6_ack_b", {30'd0, ack1, ack0}, 32'b01);
    chk("t6_rdata_b", rdata0, 32'hCAFE_0002);
    req0 = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
